// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with frame-boundary double
// buffering of value, decimal points and blanks, plus a ghost-suppression gap.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  an,
  output logic        dp,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_C  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

  logic [CW-1:0] count_q, count_d;
  logic [1:0]    digit_q, digit_d;

  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic          pending_q, pending_d;

  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [3:0]    disp_blank_q, disp_blank_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          frame_end;
  logic          lit;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan position: count walks one digit slot, digit advances on each wrap.
  always_comb begin
    count_d = count_q + 1'b1;
    digit_d = digit_q;
    if (count_q == LAST_C) begin
      count_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  assign frame_end = (digit_q == 2'd3) && (count_q == LAST_C);

  // load is a one-cycle strobe with no backpressure: a later load before the
  // frame end overwrites the pending data, and a load on the frame-end edge
  // bypasses straight into the display register.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
      pending_d    = 1'b1;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        disp_val_d   = value;
        disp_dp_d    = dp_in;
        disp_blank_d = blank;
      end else if (pending_q) begin
        disp_val_d   = pend_val_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
    end
  end

  // Pins decode the pre-edge scan position, so they lag the counters by one cycle.
  always_comb begin
    nibble = disp_val_q[{digit_q, 2'b00} +: 4];
    lit    = (count_q >= BLANK_C) && !disp_blank_q[digit_q];
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = hex7(nibble);
      dp_d  = ~disp_dp_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      digit_q      <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      count_q      <= count_d;
      digit_q      <= digit_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign pending = pending_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=8, BLANK_CYCLES=2:
// scan timing, load/commit, tearing, commit-edge bypass, blanking, async reset.
module tb_seven_seg_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic        pending;
  logic [3:0]  an;
  logic        dp;
  logic [6:0]  seg;

  int n_checks;
  int n_fail;

  logic [11:0] exp_q[$];

  seven_seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .dp_in   (dp_in),
    .blank   (blank),
    .load    (load),
    .pending (pending),
    .an      (an),
    .dp      (dp),
    .seg     (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v;
    dp_in = d;
    blank = b;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Expected pins for the 32 edges of one frame, from the edge-numbering rules.
  task automatic check_frame(input string tag, input logic [15:0] v,
                             input logic [3:0] d, input logic [3:0] b);
    logic [11:0] e;
    for (int k = 1; k <= 4 * RD; k++) begin
      int p;
      int dg;
      logic [3:0] nib;
      p  = (k - 1) % RD;
      dg = (k - 1) / RD;
      nib = v[dg*4 +: 4];
      if (p >= BC && !b[dg]) e = {~(4'b0001 << dg), ~d[dg], seg_of(nib)};
      else                   e = {4'hF, 1'b1, 7'h7F};
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check_eq({tag, "_an"}, {28'd0, an}, {28'd0, e[11:8]});
      check_eq({tag, "_dp"}, {31'd0, dp}, {31'd0, e[7]});
      check_eq({tag, "_seg"}, {25'd0, seg}, {25'd0, e[6:0]});
      check_eq({tag, "_pend"}, {31'd0, pending}, 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    value = '0;
    dp_in = '0;
    blank = '0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_an", {28'd0, an}, 32'hF);
    check_eq("rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("rst_dp", {31'd0, dp}, 32'd1);
    check_eq("rst_pend", {31'd0, pending}, 32'd0);
    rst_n = 1'b1;

    check_frame("scan0", 16'h0000, 4'b0000, 4'b0000);

    idle(4);
    do_load(16'hF8A1, 4'b0100, 4'b0000);
    check_eq("load_pend_rise", {31'd0, pending}, 32'd1);
    idle(26);
    check_eq("load_pend_hold", {31'd0, pending}, 32'd1);
    tick();
    check_eq("load_pend_fall", {31'd0, pending}, 32'd0);
    check_frame("f8a1", 16'hF8A1, 4'b0100, 4'b0000);

    idle(2);
    do_load(16'h1234, 4'b0000, 4'b0000);
    idle(15);
    do_load(16'h5678, 4'b0000, 4'b0000);
    idle(12);
    check_eq("tear_pend", {31'd0, pending}, 32'd1);
    tick();
    check_frame("no_tear", 16'h5678, 4'b0000, 4'b0000);

    idle(4);
    do_load(16'h1111, 4'b0000, 4'b0000);
    idle(26);
    check_eq("byp_pend_pre", {31'd0, pending}, 32'd1);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    check_eq("byp_pend_post", {31'd0, pending}, 32'd0);
    check_frame("bypass", 16'hABCD, 4'b0000, 4'b0000);

    idle(5);
    do_load(16'h8888, 4'b0000, 4'b1010);
    idle(26);
    check_frame("blank", 16'h8888, 4'b0000, 4'b1010);

    idle(2);
    do_load(16'h1234, 4'b0000, 4'b0000);
    idle(17);
    check_eq("mid_an_lit", {28'd0, an}, 32'hB);
    check_eq("mid_pend", {31'd0, pending}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_an", {28'd0, an}, 32'hF);
    check_eq("arst_seg", {25'd0, seg}, 32'h7F);
    check_eq("arst_dp", {31'd0, dp}, 32'd1);
    check_eq("arst_pend", {31'd0, pending}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame("post_rst", 16'h0000, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
